div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider.
- It is the responder to the execute stage's divide handshake (div_valid/div_32 in, div_ready/div_result out).
- It serves DIV/REM/DIVW/REMW and their unsigned variants.
- The execute stage holds div_valid and stalls until div_ready pulses.
- The divider returns quotient and remainder packed into a single 128-bit result.

Parameters:
- XLEN, 64, operand width; the 32-bit mode always uses bits [31:0].

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- div_valid  input  1  request; held high by requester until div_ready seen
- div_32  input  1  1 = W-form (32-bit operands/results)
- div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- div_flush  input  1  abort current op (pipeline flush), no result returned
- dividend  input  XLEN  op1, sampled only on acceptance
- divisor  input  XLEN  op2, sampled only on acceptance
- div_ready  output  1  one-cycle pulse, result valid
- div_result  output  2*XLEN  [63:0] quotient, [127:64] remainder; in 32-bit mode quotient in [31:0], remainder in [95:64], each sign-extended to its 64-bit half

Behaviour:
- Reset (rst=0, async): state=IDLE, div_ready=0, div_result=0, counter=0. Reset mid-operation discards the operation.
- All outputs are registered.
- States:
  - IDLE→BUSY: on div_valid & ~div_flush & ~div_ready. Capture |a|, |b|, a_sign, b_sign, div_32, signed, divzero=(b==0), count=N-1 (N=64, or 32 if div_32).
  - 32-bit mode: operands are first extended from bit 31 (sign if signed, zero otherwise).
  - The ~div_ready guard prevents re-accepting the still-asserted request in the cycle the result is returned.
- BUSY: one restoring step per cycle.
  - rem' = {rem, q_msb}; if rem' >= |b|, subtract and shift in 1, else shift in 0.
  - count decrements; at count==0 go to FIX.
- FIX: apply sign correction.
  - Quotient is negated iff signed & (a_sign^b_sign) & ~divzero.
  - Remainder is negated iff signed & a_sign.
  - Register div_result, set div_ready=1 for exactly one cycle, go to IDLE.
- Latency: valid first seen in IDLE at cycle 0 → div_ready high in cycle N+2 (66 for 64-bit, 34 for 32-bit).
- Divide by zero: quotient = all ones, remainder = dividend. This falls out of the sign rules above.
- Signed overflow (most-negative / -1): quotient = dividend, remainder = 0. This also falls out naturally: |a|=2^(N-1), result is not negated.
- div_flush in any state: next state IDLE, div_ready stays 0, div_result holds its last value. div_flush has priority over div_valid.
- div_valid dropping while BUSY without a flush is a protocol violation. The block ignores it and completes the operation.

Optional Feature:
- DIV_EARLY_OUT_EN. When defined, IDLE goes directly to FIX (skipping BUSY) when:
  - divisor==0, or
  - signed overflow, or
  - |a| < |b| (quotient 0, remainder a).
- Early-out gives div_ready in cycle 2.
- Without the macro, every operation takes the full N+2 cycles. Results are identical either way.

Decomposition:
- Shared defines file holds:
  - XLEN-derived widths
  - state encodings DIV_IDLE/DIV_BUSY/DIV_FIX (2-bit)
  - result field offsets: quotient low, remainder at bit 64, 32-bit remainder at bit 64
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and next quotient.
- The FSM, counter and sign fixup stay in div_unit.

Test Plan:
- Unsigned 64-bit: dividend=100, divisor=7, signed=0 → div_ready in cycle 66, quotient=14, remainder=2; div_ready low in cycles 67–68 while div_valid is still high, new op accepted only after that.
- Signed 32-bit: dividend=0xFFFFFFF9 (-7), divisor=2, div_32=1 → quotient [63:0]=0xFFFFFFFFFFFFFFFD (-3), remainder [127:64]=0xFFFFFFFFFFFFFFFF (-1), ready in cycle 34.
- Divide by zero, signed: dividend=-5, divisor=0 → quotient=0xFFFFFFFFFFFFFFFF, remainder=0xFFFFFFFFFFFFFFFB; cycle 2 with DIV_EARLY_OUT_EN, cycle 66 without.
- Overflow: dividend=0x8000000000000000, divisor=-1, signed → quotient=0x8000000000000000, remainder=0.
- Flush: start 64-bit op, assert div_flush at cycle 20 → no div_ready ever for it; next request of 9/3 returns quotient=3, remainder=0 with fresh latency.
- Async reset: assert rst=0 mid-BUSY between clock edges → div_ready=0 and div_result=0 immediately; after release, a 10/4 request gives quotient=2, remainder=2.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, FSM encoding and result field offsets for div_unit. Rev 1.0
`default_nettype none

package div_unit_pkg;

  localparam int XLEN      = 64;
  localparam int RES_W     = 2 * XLEN;
  localparam int CNT_W     = $clog2(XLEN);
  localparam int QUOT_LSB  = 0;
  localparam int REM_LSB   = 64;
  localparam int REM32_LSB = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration (shift, compare, conditional subtract). Rev 1.0
`default_nettype none

module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // The shifted remainder can exceed XLEN bits, but whenever it is >= divisor
  // the difference is below the divisor, so an XLEN-bit subtract is exact.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign ge      = (shifted >= {1'b0, divisor_i});
  assign diff    = shifted[XLEN-1:0] - divisor_i;
  assign rem_o   = ge ? diff : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ge};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for DIV/REM(U)(W).
// Defining DIV_EARLY_OUT_EN skips iteration for divide-by-zero, overflow and |a|<|b|. Rev 1.0
`default_nettype none

module div_unit
  import div_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  input  logic             div_32,
  input  logic             div_signed,
  input  logic             div_flush,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  output logic             div_ready,
  output logic [RES_W-1:0] div_result
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  absb_q, absb_d;
  logic             asign_q, asign_d;
  logic             bsign_q, bsign_d;
  logic             is32_q, is32_d;
  logic             divzero_q, divzero_d;
  logic             ready_q, ready_d;
  logic [RES_W-1:0] result_q, result_d;

  logic [XLEN-1:0]  a_ext, b_ext, abs_a, abs_b;
  logic             a_sign, b_sign;
  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN-1:0]  q_fix, r_fix;

  // W-forms extend from bit 31 so the 64-bit datapath sees the true operand value.
  assign a_ext  = div_32 ? (div_signed ? sext32(dividend) : {{(XLEN-32){1'b0}}, dividend[31:0]})
                         : dividend;
  assign b_ext  = div_32 ? (div_signed ? sext32(divisor)  : {{(XLEN-32){1'b0}}, divisor[31:0]})
                         : divisor;
  assign a_sign = div_signed & a_ext[XLEN-1];
  assign b_sign = div_signed & b_ext[XLEN-1];
  assign abs_a  = a_sign ? -a_ext : a_ext;
  assign abs_b  = b_sign ? -b_ext : b_ext;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (absb_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // asign_q/bsign_q already include the signed qualifier.
  assign q_fix = ((asign_q ^ bsign_q) & ~divzero_q) ? -quo_q : quo_q;
  assign r_fix = asign_q ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] min_neg;
  logic            ovf;
  assign min_neg = div_32 ? {{(XLEN-32){1'b0}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
  assign ovf     = a_sign & (b_ext == {XLEN{1'b1}}) & (abs_a == min_neg);
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    absb_d    = absb_q;
    asign_d   = asign_q;
    bsign_d   = bsign_q;
    is32_d    = is32_q;
    divzero_d = divzero_q;
    ready_d   = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (div_valid && !ready_q) begin
          asign_d   = a_sign;
          bsign_d   = b_sign;
          is32_d    = div_32;
          divzero_d = (b_ext == '0);
          absb_d    = abs_b;
          rem_d     = '0;
          // Dividend sits at the top of the shift register so its MSB feeds the first step.
          quo_d     = div_32 ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
          count_d   = div_32 ? CNT_W'(31) : CNT_W'(XLEN-1);
          state_d   = DIV_BUSY;
`ifdef DIV_EARLY_OUT_EN
          if (b_ext == '0) begin
            quo_d   = '1;
            rem_d   = abs_a;
            state_d = DIV_FIX;
          end else if (ovf) begin
            quo_d   = abs_a;
            rem_d   = '0;
            state_d = DIV_FIX;
          end else if (abs_a < abs_b) begin
            quo_d   = '0;
            rem_d   = abs_a;
            state_d = DIV_FIX;
          end
`endif
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (count_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DIV_FIX: begin
        if (is32_q) begin
          result_d[QUOT_LSB +: XLEN]  = sext32(q_fix);
          result_d[REM32_LSB +: XLEN] = sext32(r_fix);
        end else begin
          result_d[QUOT_LSB +: XLEN] = q_fix;
          result_d[REM_LSB +: XLEN]  = r_fix;
        end
        ready_d = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (div_flush) begin
      state_d  = DIV_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      absb_q    <= '0;
      asign_q   <= 1'b0;
      bsign_q   <= 1'b0;
      is32_q    <= 1'b0;
      divzero_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      absb_q    <= absb_d;
      asign_q   <= asign_d;
      bsign_q   <= bsign_d;
      is32_q    <= is32_d;
      divzero_q <= divzero_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign div_ready  = ready_q;
  assign div_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus handshake, flush and async-reset sequences for div_unit.
`default_nettype none

module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif
  localparam int BUDGET = 100;

  logic         clk;
  logic         rst;
  logic         div_valid;
  logic         div_32;
  logic         div_signed;
  logic         div_flush;
  logic [63:0]  dividend;
  logic [63:0]  divisor;
  logic         div_ready;
  logic [127:0] div_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          is32;
    bit          sgn;
    bit          early;
    logic [63:0] q;
    logic [63:0] r;
  } vec_t;

  vec_t vecs[14];

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_32     (div_32),
    .div_signed (div_signed),
    .div_flush  (div_flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Counts cycles from the request cycle (cycle 0) until div_ready is seen.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (div_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic watch_no_ready(input string nm, input int cycles);
    int pulses;
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (div_ready) pulses++;
    end
    chk(nm, 64'(pulses), 64'd0);
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int lat;
    int exp_lat;
    exp_lat = (EARLY_EN && v.early) ? 2 : (v.is32 ? 34 : 66);
    @(negedge clk);
    dividend   = v.a;
    divisor    = v.b;
    div_32     = v.is32;
    div_signed = v.sgn;
    div_valid  = 1'b1;
    wait_ready(lat);
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    if (lat > 0) begin
      chk({nm, "_quot"}, div_result[63:0], v.q);
      chk({nm, "_rem"}, div_result[127:64], v.r);
    end
    @(negedge clk);
    div_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 64'(div_ready), 64'd0);
  endtask

  initial begin
    int lat;
    rst        = 1'b0;
    div_valid  = 1'b0;
    div_32     = 1'b0;
    div_signed = 1'b0;
    div_flush  = 1'b0;
    dividend   = '0;
    divisor    = '0;

    //           a                       b                      32 sgn early q                      r
    vecs[0]  = '{64'd100,                64'd7,                 0, 0, 0, 64'd14,                64'd2};
    vecs[1]  = '{64'h0000_0000_FFFF_FFF9, 64'd2,                1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[3]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 64'h8000_0000_0000_0000, 64'd0};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5]  = '{64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    vecs[6]  = '{64'h0000_0000_FFFF_FFFF, 64'd1,                1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[7]  = '{64'd3,                  64'd10,                0, 0, 1, 64'd0,                 64'd3};
    vecs[8]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 1, 64'hFFFF_FFFF_8000_0000, 64'd0};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h10,               0, 0, 0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF};
    vecs[10] = '{64'h0000_0000_1234_5678, 64'd0,                1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5678};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 0, 64'd14,                64'hFFFF_FFFF_FFFF_FFFE};
    vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'd1,                 64'd0};
    vecs[13] = '{64'h0000_0000_0000_0064, 64'h0000_0000_FFFF_FFF9, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2};

    #12;
    chk("reset_ready", 64'(div_ready), 64'd0);
    chk("reset_quot", div_result[63:0], 64'd0);
    chk("reset_rem", div_result[127:64], 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Requester keeps div_valid high after the result pulse.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; div_32 = 1'b0; div_signed = 1'b0; div_valid = 1'b1;
    wait_ready(lat);
    chk("hold_lat", 64'(lat), 64'd66);
    chk("hold_quot", div_result[63:0], 64'd14);
    chk("hold_rem", div_result[127:64], 64'd2);
    @(posedge clk); #1;
    chk("hold_c67_ready", 64'(div_ready), 64'd0);
    @(posedge clk); #1;
    chk("hold_c68_ready", 64'(div_ready), 64'd0);
    @(negedge clk);
    div_valid = 1'b0; div_flush = 1'b1;
    @(negedge clk);
    div_flush = 1'b0;
    watch_no_ready("hold_flushed", 80);
    chk("hold_keep_quot", div_result[63:0], 64'd14);

    foreach (vecs[i]) run_op($sformatf("v%0d", i), vecs[i]);

    // Flush in the middle of a 64-bit operation.
    @(negedge clk);
    dividend = 64'd1000; divisor = 64'd3; div_32 = 1'b0; div_signed = 1'b0; div_valid = 1'b1;
    for (int k = 0; k < 20; k++) @(posedge clk);
    @(negedge clk);
    div_flush = 1'b1; div_valid = 1'b0;
    @(negedge clk);
    div_flush = 1'b0;
    watch_no_ready("flush_no_ready", 80);
    run_op("after_flush", '{64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 64'd0});

    // Asynchronous reset between clock edges while busy.
    @(negedge clk);
    dividend = 64'd123; divisor = 64'd5; div_32 = 1'b0; div_signed = 1'b0; div_valid = 1'b1;
    for (int k = 0; k < 10; k++) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0; div_valid = 1'b0;
    #1;
    chk("arst_ready", 64'(div_ready), 64'd0);
    chk("arst_quot", div_result[63:0], 64'd0);
    chk("arst_rem", div_result[127:64], 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    watch_no_ready("arst_no_ready", 70);
    run_op("after_arst", '{64'd10, 64'd4, 1'b0, 1'b0, 1'b0, 64'd2, 64'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
